sequential_divider: RTL and testbench

//  Restoring shift-and-subtract divider. It is the inverse of the sequential multiplier and uses the same i_valid/o_accept handshake.

---
 rtl/sequential_divider_pkg.sv | 14 +
 rtl/sequential_divider_step.sv | 23 ++
 rtl/sequential_divider.sv | 169 ++++++++++++++++
 tb/tb_sequential_divider.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sequential_divider_pkg.sv
// Shared encodings and helpers for the restoring sequential divider.
// Also used by the optional signed build (SEQUENTIAL_DIVIDER_SIGNED_EN).
package sequential_divider_pkg;

  localparam logic [1:0] SM_IDLE = 2'b00;
  localparam logic [1:0] SM_DIV  = 2'b01;
  localparam logic [1:0] SM_DONE = 2'b10;

  // Width of a down-counter that must hold n-1.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sequential_divider_step.sv
// One restoring shift-and-subtract iteration: shift in a dividend bit,
// subtract the divisor when it fits, and report the quotient bit.
module sequential_divider_step #(
  parameter int DW = 8
) (
  input  logic [DW:0]   p_i,
  input  logic          bit_i,
  input  logic [DW-1:0] div_i,
  output logic [DW:0]   p_o,
  output logic          q_o
);

  logic [DW+1:0] ext;

  // The incoming P is always below the divisor, so its top bit is zero and
  // the widened shift is numerically identical to {P[DW-1:0], bit}.
  always_comb begin
    ext = {p_i, bit_i};
    q_o = (ext >= {2'b00, div_i});
    p_o = q_o ? (DW+1)'(ext - {2'b00, div_i}) : ext[DW:0];
  end

endmodule

// File: rtl/sequential_divider.sv
// Restoring sequential divider, one quotient bit per clock, valid/accept handshake.
// Define SEQUENTIAL_DIVIDER_SIGNED_EN for two's-complement operands.
//
//  state   | meaning
//  SM_IDLE | waiting for i_valid; operands captured on the request edge
//  SM_DIV  | N shift-and-subtract iterations, MSB first
//  SM_DONE | result presented, o_accept high until i_valid drops
module sequential_divider
  import sequential_divider_pkg::*;
#(
  parameter int DATA_WIDTH_N = 8,
  parameter int DATA_WIDTH_D = 8
) (
  input  logic                    i_clk,
  input  logic                    i_nrst,
  input  logic [DATA_WIDTH_N-1:0] i_n,
  input  logic [DATA_WIDTH_D-1:0] i_d,
  input  logic                    i_valid,
  output logic [DATA_WIDTH_N-1:0] o_q,
  output logic [DATA_WIDTH_D-1:0] o_r,
  output logic                    o_div_zero,
  output logic                    o_accept
);

  localparam int N  = DATA_WIDTH_N;
  localparam int D  = DATA_WIDTH_D;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  n_q, n_d;
  logic [D-1:0]  div_q, div_d;
  logic [D:0]    p_q, p_d;
  logic [N-1:0]  oq_q, oq_d;
  logic [D-1:0]  or_q, or_d;
  logic          dz_q, dz_d;

  logic [D:0]    step_p;
  logic          step_bit;
  logic [N-1:0]  n_cap, zero_q, quot_raw, quot_fix;
  logic [D-1:0]  div_cap, rem_fix;

`ifdef SEQUENTIAL_DIVIDER_SIGNED_EN
  logic          qneg_q, qneg_d;
  logic          rneg_q, rneg_d;
`endif

  sequential_divider_step #(.DW(D)) u_step (
    .p_i   (p_q),
    .bit_i (n_q[N-1]),
    .div_i (div_q),
    .p_o   (step_p),
    .q_o   (step_bit)
  );

  // n_q doubles as the quotient: dividend bits leave at the top while
  // quotient bits enter at the bottom.
  assign quot_raw = {n_q[N-2:0], step_bit};

`ifdef SEQUENTIAL_DIVIDER_SIGNED_EN
  // A D-bit magnitude register suffices: |most-negative| = 2^(D-1) fits unsigned.
  always_comb begin
    n_cap    = i_n[N-1] ? -i_n : i_n;
    div_cap  = i_d[D-1] ? -i_d : i_d;
    zero_q   = i_n[N-1] ? {{(N-1){1'b0}}, 1'b1} : {N{1'b1}};
    quot_fix = qneg_q ? -quot_raw : quot_raw;
    rem_fix  = rneg_q ? -step_p[D-1:0] : step_p[D-1:0];
  end
`else
  always_comb begin
    n_cap    = i_n;
    div_cap  = i_d;
    zero_q   = {N{1'b1}};
    quot_fix = quot_raw;
    rem_fix  = step_p[D-1:0];
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    div_d   = div_q;
    p_d     = p_q;
    oq_d    = oq_q;
    or_d    = or_q;
    dz_d    = dz_q;
`ifdef SEQUENTIAL_DIVIDER_SIGNED_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif
    case (state_q)
      SM_IDLE: begin
        if (i_valid) begin
          n_d   = n_cap;
          div_d = div_cap;
          p_d   = '0;
          cnt_d = CNT_LAST;
          oq_d  = '0;
          or_d  = '0;
          dz_d  = 1'b0;
`ifdef SEQUENTIAL_DIVIDER_SIGNED_EN
          qneg_d = i_n[N-1] ^ i_d[D-1];
          rneg_d = i_n[N-1];
`endif
          if (i_d == '0) begin
            oq_d    = zero_q;
            or_d    = i_n[D-1:0];
            dz_d    = 1'b1;
            state_d = SM_DONE;
          end else begin
            state_d = SM_DIV;
          end
        end
      end
      SM_DIV: begin
        p_d   = step_p;
        n_d   = quot_raw;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          oq_d    = quot_fix;
          or_d    = rem_fix;
          state_d = SM_DONE;
        end
      end
      SM_DONE: begin
        if (!i_valid) state_d = SM_IDLE;
      end
      default: state_d = SM_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      state_q <= SM_IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      div_q   <= '0;
      p_q     <= '0;
      oq_q    <= '0;
      or_q    <= '0;
      dz_q    <= 1'b0;
`ifdef SEQUENTIAL_DIVIDER_SIGNED_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      div_q   <= div_d;
      p_q     <= p_d;
      oq_q    <= oq_d;
      or_q    <= or_d;
      dz_q    <= dz_d;
`ifdef SEQUENTIAL_DIVIDER_SIGNED_EN
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign o_q        = oq_q;
  assign o_r        = or_q;
  assign o_div_zero = dz_q;
  assign o_accept   = (state_q == SM_DONE);

endmodule

// File: tb/tb_sequential_divider.sv
// Bench for sequential_divider (N=D=8): vector table, hand-written corner
// sequences and a random sweep checked against a native-arithmetic model.
module tb_sequential_divider;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
  } exp_t;

  typedef struct packed {
    logic [7:0] n;
    logic [7:0] d;
    exp_t       e;
  } vec_t;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic [7:0] i_n = '0;
  logic [7:0] i_d = '0;
  logic       i_valid = 1'b0;
  logic [7:0] o_q, o_r;
  logic       o_div_zero, o_accept;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];
  exp_t last_exp;
  int   last_lat;

  always #5 clk = ~clk;

  sequential_divider #(.DATA_WIDTH_N(8), .DATA_WIDTH_D(8)) dut (
    .i_clk      (clk),
    .i_nrst     (nrst),
    .i_n        (i_n),
    .i_d        (i_d),
    .i_valid    (i_valid),
    .o_q        (o_q),
    .o_r        (o_r),
    .o_div_zero (o_div_zero),
    .o_accept   (o_accept)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] n, input logic [7:0] d);
    exp_t m;
`ifdef SEQUENTIAL_DIVIDER_SIGNED_EN
    int sn, sd;
    sn = $signed(n);
    sd = $signed(d);
    if (d == 8'd0) begin
      m.q = (sn < 0) ? 8'h01 : 8'hFF; m.r = n; m.dz = 1'b1;
    end else begin
      m.q = 8'(sn / sd); m.r = 8'(sn % sd); m.dz = 1'b0;
    end
`else
    if (d == 8'd0) begin
      m.q = 8'hFF; m.r = n; m.dz = 1'b1;
    end else begin
      m.q = n / d; m.r = n % d; m.dz = 1'b0;
    end
`endif
    return m;
  endfunction

  task automatic compare_result(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    last_exp = e;
    check({tag, "_q"},  o_q, e.q);
    check({tag, "_r"},  o_r, e.r);
    check({tag, "_dz"}, o_div_zero, e.dz);
  endtask

  // Request, capture edge, then wait for accept. last_lat counts rising edges
  // after the capture edge until o_accept is seen (N normally; a zero divisor
  // goes straight to SM_DONE, so accept is already up after the capture edge).
  task automatic issue(input logic [7:0] n, input logic [7:0] d, input exp_t e,
                       input bit toggle, input string tag);
    int lat;
    sb.push_back(e);
    i_n = n; i_d = d; i_valid = 1'b1;
    tick();
    lat = 0;
    while (!o_accept && lat < 40) begin
      if (toggle) begin
        i_n = 8'($urandom); i_d = 8'($urandom);
      end
      tick();
      lat++;
    end
    check({tag, "_accept"}, o_accept, 1'b1);
    last_lat = lat;
    check({tag, "_latency"}, lat, (d == 8'd0) ? 0 : 8);
    compare_result(tag);
  endtask

  task automatic release_req(input string tag);
    i_valid = 1'b0;
    tick();
    check({tag, "_accept_fall"}, o_accept, 1'b0);
  endtask

  vec_t tbl[$];

  initial begin
`ifdef SEQUENTIAL_DIVIDER_SIGNED_EN
    tbl.push_back('{8'hF9, 8'h02, '{8'hFD, 8'hFF, 1'b0}});
    tbl.push_back('{8'h80, 8'hFF, '{8'h80, 8'h00, 1'b0}});
    tbl.push_back('{8'h07, 8'hFE, '{8'hFD, 8'h01, 1'b0}});
    tbl.push_back('{8'h05, 8'h00, '{8'hFF, 8'h05, 1'b1}});
    tbl.push_back('{8'hFB, 8'h00, '{8'h01, 8'hFB, 1'b1}});
    tbl.push_back('{8'h80, 8'h01, '{8'h80, 8'h00, 1'b0}});
    tbl.push_back('{8'h7F, 8'h80, '{8'h00, 8'h7F, 1'b0}});
    tbl.push_back('{8'h80, 8'h80, '{8'h01, 8'h00, 1'b0}});
    tbl.push_back('{8'hFF, 8'h03, '{8'h00, 8'hFF, 1'b0}});
    tbl.push_back('{8'd100, 8'd7, '{8'd14, 8'd2, 1'b0}});
`else
    tbl.push_back('{8'd100, 8'd7,   '{8'd14,  8'd2,   1'b0}});
    tbl.push_back('{8'd5,   8'd0,   '{8'hFF,  8'd5,   1'b1}});
    tbl.push_back('{8'd255, 8'd1,   '{8'd255, 8'd0,   1'b0}});
    tbl.push_back('{8'd9,   8'd3,   '{8'd3,   8'd0,   1'b0}});
    tbl.push_back('{8'd0,   8'd5,   '{8'd0,   8'd0,   1'b0}});
    tbl.push_back('{8'd255, 8'd255, '{8'd1,   8'd0,   1'b0}});
    tbl.push_back('{8'd1,   8'd2,   '{8'd0,   8'd1,   1'b0}});
    tbl.push_back('{8'd200, 8'd13,  '{8'd15,  8'd5,   1'b0}});
    tbl.push_back('{8'd128, 8'd128, '{8'd1,   8'd0,   1'b0}});
    tbl.push_back('{8'd7,   8'd8,   '{8'd0,   8'd7,   1'b0}});
    tbl.push_back('{8'd0,   8'd0,   '{8'hFF,  8'd0,   1'b1}});
    tbl.push_back('{8'd254, 8'd127, '{8'd2,   8'd0,   1'b0}});
`endif

    // Reset state
    tick(); tick();
    check("rst_accept", o_accept, 1'b0);
    check("rst_q", o_q, 8'd0);
    check("rst_r", o_r, 8'd0);
    check("rst_dz", o_div_zero, 1'b0);
    nrst = 1'b1;
    tick();

    foreach (tbl[i]) begin
      issue(tbl[i].n, tbl[i].d, tbl[i].e, 1'b0, $sformatf("vec%0d", i));
      release_req($sformatf("vec%0d", i));
    end

    // Hold i_valid in SM_DONE: outputs must not move.
    issue(8'd100, 8'd7, model(8'd100, 8'd7), 1'b0, "hold");
    for (int k = 0; k < 5; k++) begin
      tick();
      check("hold_accept", o_accept, 1'b1);
      check("hold_q", o_q, last_exp.q);
      check("hold_r", o_r, last_exp.r);
    end
    release_req("hold");
    issue(8'd255, 8'd1, model(8'd255, 8'd1), 1'b0, "after_hold");
    release_req("after_hold");

    // Reset during the 4th iteration aborts the operation.
    i_n = 8'd100; i_d = 8'd7; i_valid = 1'b1;
    tick();
    tick(); tick(); tick();
    nrst = 1'b0;
    tick();
    check("midrst_accept", o_accept, 1'b0);
    check("midrst_q", o_q, 8'd0);
    check("midrst_r", o_r, 8'd0);
    check("midrst_dz", o_div_zero, 1'b0);
    i_valid = 1'b0;
    nrst = 1'b1;
    tick();
    issue(8'd9, 8'd3, model(8'd9, 8'd3), 1'b0, "post_rst");
    release_req("post_rst");

    // i_valid dropped mid-division: completes, one cycle of SM_DONE, back to idle.
    begin
      int lat;
      sb.push_back(model(8'd200, 8'd13));
      i_n = 8'd200; i_d = 8'd13; i_valid = 1'b1;
      tick();
      tick();
      i_valid = 1'b0;
      lat = 1;
      while (!o_accept && lat < 40) begin
        tick();
        lat++;
      end
      check("drop_accept", o_accept, 1'b1);
      check("drop_latency", lat, 8);
      compare_result("drop");
      tick();
      check("drop_accept_fall", o_accept, 1'b0);
    end

    // Random pairs with operand toggling during SM_DIV.
    for (int k = 0; k < 2000; k++) begin
      logic [7:0] rn, rd;
      rn = 8'($urandom);
      rd = (k % 50 == 0) ? 8'd0 : 8'($urandom);
      issue(rn, rd, model(rn, rd), (k % 2) == 1, "rand");
      release_req("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
